// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM responder with byte-lane writes and a fixed read latency.
// Define MEM_RESPONDER_STATS_EN to add saturating read/write/error counters.
module mem_responder #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int MEM_WORDS        = 4096,
    parameter int READ_LATENCY     = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable_in,
    input  logic [3:0]                    wb_in,
    input  logic [MEMORY_BUS_WIDTH-3:0]   addr_in,
    input  logic [MEMORY_BUS_WIDTH-1:0]   data_in,
    output logic [MEMORY_BUS_WIDTH-1:0]   data_out,
    output logic                          rvalid_out,
    output logic                          err_out
`ifdef MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0]                   rd_count_out,
    output logic [15:0]                   wr_count_out,
    output logic [7:0]                    err_count_out
`endif
);
    localparam int AW = MEMORY_BUS_WIDTH - 2;
    localparam int IW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    logic [MEMORY_BUS_WIDTH-1:0] mem_q [MEM_WORDS];
    logic [READ_LATENCY-1:0]     vld_q, vld_d;
    logic [MEMORY_BUS_WIDTH-1:0] dat_q [READ_LATENCY];
    logic [MEMORY_BUS_WIDTH-1:0] dat_d [READ_LATENCY];
    logic                        err_q, err_d;
    logic                        in_range, rd, wr;
    logic [IW-1:0]               idx;
    logic [MEMORY_BUS_WIDTH-1:0] rd_word, wr_word;

    always_comb begin
        in_range = addr_in < AW'(MEM_WORDS);
        idx      = addr_in[IW-1:0];
        rd       = enable_in && wb_in == 4'b0000;
        wr       = enable_in && wb_in != 4'b0000;
        rd_word  = in_range ? mem_q[idx] : '0;
        for (int i = 0; i < 4; i++)
            wr_word[8*i +: 8] = wb_in[i] ? data_in[8*i +: 8] : rd_word[8*i +: 8];
        err_d    = err_q | (enable_in & ~in_range);
        vld_d    = READ_LATENCY'({vld_q, rd});
        dat_d    = dat_q;
        dat_d[0] = rd ? rd_word : dat_q[0];
        // each stage only loads on a valid, so the last stage holds the previous result
        for (int i = 1; i < READ_LATENCY; i++)
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
    end

    always_ff @(posedge clock) begin
        if (wr && in_range)
            mem_q[idx] <= wr_word;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            dat_q <= '{default: '0};
            err_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
            err_q <= err_d;
        end
    end

    assign data_out   = dat_q[READ_LATENCY-1];
    assign rvalid_out = vld_q[READ_LATENCY-1];
    assign err_out    = err_q;

`ifdef MEM_RESPONDER_STATS_EN
    logic [15:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic [7:0]  er_cnt_q, er_cnt_d;

    always_comb begin
        rd_cnt_d = (rd && ~&rd_cnt_q) ? rd_cnt_q + 16'd1 : rd_cnt_q;
        wr_cnt_d = (wr && ~&wr_cnt_q) ? wr_cnt_q + 16'd1 : wr_cnt_q;
        er_cnt_d = (enable_in && !in_range && ~&er_cnt_q) ? er_cnt_q + 8'd1 : er_cnt_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            er_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            er_cnt_q <= er_cnt_d;
        end
    end

    assign rd_count_out  = rd_cnt_q;
    assign wr_count_out  = wr_cnt_q;
    assign err_count_out = er_cnt_q;
`endif
endmodule
